// File: rtl/clk_phase_gen_if.sv
// -----------------------------------------------------------------------------
// clk_phase_gen_if
// Groups the phase outputs, lock status and the dynamic phase-step handshake
// of clk_phase_gen into one bundle.
//   clk_out   [PHASES-1:0]     : phase outputs (driven by the generator)
//   locked                     : outputs valid and running
//   ps_en                      : phase-step request pulse (driven by the user)
//   ps_incdec                  : 1 = delay all phases, 0 = advance all phases
//   ps_done                    : one-cycle pulse when a step has been applied
//   ps_busy                    : a step is pending
//   ps_offset [$clog2(DIV)-1:0]: current phase offset
// Modports: master = generator side, slave = consumer side.
// -----------------------------------------------------------------------------
interface clk_phase_gen_if #(
   parameter int DIV    = 8,
   parameter int PHASES = 4
);
   logic [PHASES-1:0]      clk_out;
   logic                   locked;
   logic                   ps_en;
   logic                   ps_incdec;
   logic                   ps_done;
   logic                   ps_busy;
   logic [$clog2(DIV)-1:0] ps_offset;

   modport master (
      output clk_out, locked, ps_done, ps_busy, ps_offset,
      input  ps_en, ps_incdec
   );

   modport slave (
      input  clk_out, locked, ps_done, ps_busy, ps_offset,
      output ps_en, ps_incdec
   );
endinterface

// File: rtl/clk_phase_gen.sv
// -----------------------------------------------------------------------------
// clk_phase_gen
// Fully synchronous multi-phase clock generator. Divides clk_in by DIV and
// produces PHASES equally spaced 50 % duty outputs after a lock/settle period,
// with an optional DCM-style dynamic phase-step handshake.
// Ports:
//   clk_in : reference clock (only clock)
//   rst    : asynchronous, active-high reset
//   bus    : clk_phase_gen_if.master (clk_out, locked, ps_* handshake)
// Build option:
//   CLK_PHASE_GEN_PHASE_STEP_EN defined   -> dynamic phase step built
//   CLK_PHASE_GEN_PHASE_STEP_EN undefined -> ps_en/ps_incdec ignored,
//                                            ps_done/ps_busy/ps_offset tied 0
// -----------------------------------------------------------------------------
module clk_phase_gen #(
   parameter int DIV         = 8,
   parameter int PHASES      = 4,
   parameter int LOCK_CYCLES = 16
) (
   input logic             clk_in,
   input logic             rst,
   clk_phase_gen_if.master bus
);
   localparam int              CW       = $clog2(DIV);
   localparam int              SPACING  = DIV / PHASES;
   localparam int              LW       = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
   localparam logic [CW-1:0]   CNT_MAX  = CW'(DIV - 1);
   localparam logic [CW-1:0]   HALF     = CW'(DIV / 2);
   localparam logic [LW-1:0]   LOCK_MAX = LW'(LOCK_CYCLES - 1);
   localparam logic [CW:0]     DIV_W    = (CW + 1)'(DIV);

   typedef enum logic {ST_WAIT = 1'b0, ST_RUN = 1'b1} state_t;

   state_t            r_state, w_state_next;
   logic [LW-1:0]     r_lock_cnt, w_lock_cnt_next;
   logic [CW-1:0]     r_cnt, w_cnt_next;
   logic [PHASES-1:0] r_clk_out, w_clk_out_next;
   logic              w_wrap;
   logic [CW-1:0]     w_offset;

   // (a - b) mod DIV for operands already in 0..DIV-1. Biasing by DIV keeps
   // the extended result positive, so one conditional subtract reduces it
   // even when DIV is not a power of two.
   function automatic logic [CW-1:0] mod_sub(input logic [CW-1:0] a, input logic [CW-1:0] b);
      logic [CW:0] diff;
      diff = {1'b0, a} + DIV_W - {1'b0, b};
      if (diff >= DIV_W) diff = diff - DIV_W;
      return diff[CW-1:0];
   endfunction

   assign w_wrap = (r_state == ST_RUN) && (r_cnt == CNT_MAX);

   // Lock/settle FSM and divide counter
   always_comb begin
      w_state_next    = r_state;
      w_lock_cnt_next = r_lock_cnt;
      w_cnt_next      = '0;
      case (r_state)
         ST_WAIT: begin
            if (r_lock_cnt == LOCK_MAX) begin
               w_state_next = ST_RUN;
            end else begin
               w_lock_cnt_next = r_lock_cnt + 1'b1;
            end
         end
         ST_RUN: begin
            w_cnt_next = w_wrap ? '0 : r_cnt + 1'b1;
         end
         default: w_state_next = ST_WAIT;
      endcase
   end

   // Phase k is high for the half period starting k*SPACING+offset after cnt=0
   genvar gi;
   generate
      for (gi = 0; gi < PHASES; gi++) begin : g_phase
         localparam logic [CW-1:0] LAG = CW'(gi * SPACING);
         assign w_clk_out_next[gi] = (r_state == ST_RUN) &&
                                     (mod_sub(mod_sub(r_cnt, LAG), w_offset) < HALF);
      end
   endgenerate

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         r_state    <= ST_WAIT;
         r_lock_cnt <= '0;
         r_cnt      <= '0;
         r_clk_out  <= '0;
      end else begin
         r_state    <= w_state_next;
         r_lock_cnt <= w_lock_cnt_next;
         r_cnt      <= w_cnt_next;
         r_clk_out  <= w_clk_out_next;
      end
   end

   assign bus.clk_out = r_clk_out;
   assign bus.locked  = (r_state == ST_RUN);

`ifdef CLK_PHASE_GEN_PHASE_STEP_EN
   logic          r_busy;
   logic          r_dir;
   logic          r_done;
   logic [CW-1:0] r_offset;
   logic          w_accept;

   assign w_accept = bus.ps_en && (r_state == ST_RUN) && !r_busy;

   // A step accepted on a wrap cycle sees r_busy only from the next cycle, so
   // it is applied at the following wrap; moving the offset only at a wrap
   // keeps every pulse at least DIV/2-1 cycles long.
   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         r_busy   <= 1'b0;
         r_dir    <= 1'b0;
         r_done   <= 1'b0;
         r_offset <= '0;
      end else begin
         r_done <= 1'b0;
         if (w_accept) begin
            r_busy <= 1'b1;
            r_dir  <= bus.ps_incdec;
         end else if (r_busy && w_wrap) begin
            r_busy <= 1'b0;
            r_done <= 1'b1;
            if (r_dir) begin
               r_offset <= (r_offset == CNT_MAX) ? '0 : r_offset + 1'b1;
            end else begin
               r_offset <= (r_offset == '0) ? CNT_MAX : r_offset - 1'b1;
            end
         end
      end
   end

   assign w_offset      = r_offset;
   assign bus.ps_done   = r_done;
   assign bus.ps_busy   = r_busy;
   assign bus.ps_offset = r_offset;
`else
   logic w_unused_ps;

   assign w_unused_ps   = bus.ps_en ^ bus.ps_incdec;
   assign w_offset      = '0;
   assign bus.ps_done   = 1'b0;
   assign bus.ps_busy   = 1'b0;
   assign bus.ps_offset = '0;
`endif

endmodule
